// File: rtl/feistel_decrypt_if.sv
// Bundle of request, SRAM read and result signals for feistel_decrypt.
// The slave modport is the decryptor's view; master is the environment side.
interface feistel_decrypt_if;
  logic        start;
  logic [31:0] L;
  logic [31:0] R;
  logic [31:0] s1_out;
  logic [31:0] s2_out;
  logic [31:0] s3_out;
  logic [31:0] s4_out;
  logic [31:0] p_out;
  logic [7:0]  s1_addr;
  logic [7:0]  s2_addr;
  logic [7:0]  s3_addr;
  logic [7:0]  s4_addr;
  logic [7:0]  p_addr;
  logic        s1_cs_l;
  logic        s2_cs_l;
  logic        s3_cs_l;
  logic        s4_cs_l;
  logic        p_cs_l;
  logic [31:0] resultL;
  logic [31:0] resultR;
  logic        busy;
  logic        done;

  modport master (
    output start, L, R, s1_out, s2_out, s3_out, s4_out, p_out,
    input  s1_addr, s2_addr, s3_addr, s4_addr, p_addr,
    input  s1_cs_l, s2_cs_l, s3_cs_l, s4_cs_l, p_cs_l,
    input  resultL, resultR, busy, done
  );

  modport slave (
    input  start, L, R, s1_out, s2_out, s3_out, s4_out, p_out,
    output s1_addr, s2_addr, s3_addr, s4_addr, p_addr,
    output s1_cs_l, s2_cs_l, s3_cs_l, s4_cs_l, p_cs_l,
    output resultL, resultR, busy, done
  );
endinterface

// File: rtl/feistel_decrypt.sv
// Sequential 16-round Feistel (Blowfish-style) decryptor reading the P-array
// and four S-boxes from external SRAMs with a two-cycle read latency.
module feistel_decrypt (
  input  logic             clk,
  input  logic             reset,
  feistel_decrypt_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, P_REQ, P_WAIT, P_XOR, S_REQ, S_WAIT, S_UPD,
    P1_REQ, P1_WAIT, P1_XOR, P0_REQ, P0_WAIT, P0_XOR, DONE
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  round;
  logic [31:0] xl, xr;
  logic [31:0] f_val;

  assign f_val     = ((bus.s1_out + bus.s2_out) ^ bus.s3_out) + bus.s4_out;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = P_REQ;
      P_REQ:   state_nx = P_WAIT;
      P_WAIT:  state_nx = P_XOR;
      P_XOR:   state_nx = S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT:  state_nx = S_UPD;
      S_UPD:   state_nx = (round == 4'd15) ? P1_REQ : P_REQ;
      P1_REQ:  state_nx = P1_WAIT;
      P1_WAIT: state_nx = P1_XOR;
      P1_XOR:  state_nx = P0_REQ;
      P0_REQ:  state_nx = P0_WAIT;
      P0_WAIT: state_nx = P0_XOR;
      P0_XOR:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and addresses exist only in the *_REQ cycles; otherwise parked.
  always_comb begin
    bus.p_cs_l  = 1'b1;
    bus.s1_cs_l = 1'b1;
    bus.s2_cs_l = 1'b1;
    bus.s3_cs_l = 1'b1;
    bus.s4_cs_l = 1'b1;
    bus.p_addr  = '0;
    bus.s1_addr = '0;
    bus.s2_addr = '0;
    bus.s3_addr = '0;
    bus.s4_addr = '0;
    unique case (state)
      P_REQ: begin
        bus.p_cs_l = 1'b0;
        bus.p_addr = 8'd17 - {4'd0, round};
      end
      P1_REQ: begin
        bus.p_cs_l = 1'b0;
        bus.p_addr = 8'd1;
      end
      P0_REQ: begin
        bus.p_cs_l = 1'b0;
        bus.p_addr = 8'd0;
      end
      S_REQ: begin
        bus.s1_cs_l = 1'b0;
        bus.s2_cs_l = 1'b0;
        bus.s3_cs_l = 1'b0;
        bus.s4_cs_l = 1'b0;
        bus.s1_addr = xl[31:24];
        bus.s2_addr = xl[23:16];
        bus.s3_addr = xl[15:8];
        bus.s4_addr = xl[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      round       <= '0;
      xl          <= '0;
      xr          <= '0;
      bus.resultL <= '0;
      bus.resultR <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (bus.start) begin
          xl    <= bus.L;
          xr    <= bus.R;
          round <= '0;
        end
        P_XOR: xl <= xl ^ bus.p_out;
        // The last round skips the half swap so the output whitening lands correctly.
        S_UPD: if (round == 4'd15) begin
          xr <= xr ^ f_val;
        end else begin
          xl    <= xr ^ f_val;
          xr    <= xl;
          round <= round + 4'd1;
        end
        P1_XOR: xr <= xr ^ bus.p_out;
        P0_XOR: begin
          xl          <= xl ^ bus.p_out;
          bus.resultL <= xl ^ bus.p_out;
          bus.resultR <= xr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_decrypt.sv
// Randomised bench for feistel_decrypt: SRAM models with two-cycle latency,
// a plain Blowfish-decrypt reference and a per-cycle output/port checker.
module tb_feistel_decrypt;

  logic clk;
  logic reset;
  feistel_decrypt_if bus ();

  feistel_decrypt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] P  [256];
  logic [31:0] S1 [256];
  logic [31:0] S2 [256];
  logic [31:0] S3 [256];
  logic [31:0] S4 [256];
  logic [31:0] fin [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAMs: address sampled at end of strobe cycle, data registered one cycle
  // later; unstrobed slots return junk so early/late use shows up.
  logic       p_v1, s_v1;
  logic [7:0] p_a1, s1_a1, s2_a1, s3_a1, s4_a1;
  logic [31:0] p_d2, s1_d2, s2_d2, s3_d2, s4_d2;
  always @(posedge clk) begin
    p_v1  <= !bus.p_cs_l;
    p_a1  <= bus.p_addr;
    s_v1  <= !bus.s1_cs_l;
    s1_a1 <= bus.s1_addr;
    s2_a1 <= bus.s2_addr;
    s3_a1 <= bus.s3_addr;
    s4_a1 <= bus.s4_addr;
    p_d2  <= p_v1 ? P[p_a1]  : $urandom;
    s1_d2 <= s_v1 ? S1[s1_a1] : $urandom;
    s2_d2 <= s_v1 ? S2[s2_a1] : $urandom;
    s3_d2 <= s_v1 ? S3[s3_a1] : $urandom;
    s4_d2 <= s_v1 ? S4[s4_a1] : $urandom;
  end
  assign bus.p_out  = p_d2;
  assign bus.s1_out = s1_d2;
  assign bus.s2_out = s2_d2;
  assign bus.s3_out = s3_d2;
  assign bus.s4_out = s4_d2;

  function automatic logic [31:0] f_fn(input logic [31:0] x);
    return ((S1[x[31:24]] + S2[x[23:16]]) ^ S3[x[15:8]]) + S4[x[7:0]];
  endfunction

  // Textbook Blowfish decryption; records each round's F input for port checks.
  task automatic model(input logic [31:0] l, input logic [31:0] r,
                       output logic [31:0] ol, output logic [31:0] orr);
    logic [31:0] xl, xr, t;
    xl = l;
    xr = r;
    for (int i = 17; i >= 2; i--) begin
      xl ^= P[i];
      fin[17 - i] = xl;
      xr ^= f_fn(xl);
      t = xl; xl = xr; xr = t;
    end
    t = xl; xl = xr; xr = t;
    xr ^= P[1];
    xl ^= P[0];
    ol  = xl;
    orr = xr;
  endtask

  function automatic logic [44:0] exp_sram(input int c);
    logic [4:0]  cs;
    logic [7:0]  pa;
    logic [31:0] sa;
    int k, r;
    cs = '1; pa = '0; sa = '0;
    if (c >= 1 && c <= 96) begin
      k = (c - 1) % 6;
      r = (c - 1) / 6;
      if (k == 0) begin cs[4] = 1'b0; pa = 8'(17 - r); end
      if (k == 3) begin cs[3:0] = '0; sa = fin[r]; end
    end else if (c == 97) begin
      cs[4] = 1'b0; pa = 8'd1;
    end else if (c == 100) begin
      cs[4] = 1'b0; pa = 8'd0;
    end
    return {cs, pa, sa};
  endfunction

  // Per-cycle checker: cyc is the model's cycle index within an operation.
  int cyc = -1;
  logic [31:0] held_l = '0, held_r = '0, pend_l, pend_r;
  logic [44:0] act_sram;
  logic [1:0]  exp_bd;
  always @(negedge clk) begin
    act_sram = {bus.p_cs_l, bus.s1_cs_l, bus.s2_cs_l, bus.s3_cs_l, bus.s4_cs_l,
                bus.p_addr, bus.s1_addr, bus.s2_addr, bus.s3_addr, bus.s4_addr};
    if (reset) begin
      cyc = -1;
      held_l = '0;
      held_r = '0;
      check("reset_outputs",
            {bus.busy, bus.done, act_sram, bus.resultL, bus.resultR},
            {2'b00, 5'h1f, 40'd0, 64'd0});
    end else begin
      if (cyc < 0 && bus.start) begin
        cyc = 0;
        model(bus.L, bus.R, pend_l, pend_r);
      end
      if (cyc == 103) begin
        held_l = pend_l;
        held_r = pend_r;
      end
      exp_bd = {cyc >= 1, cyc == 103};
      check("busy_done", {bus.busy, bus.done}, exp_bd);
      check("results", {bus.resultL, bus.resultR}, {held_l, held_r});
      check("sram_ports", act_sram, exp_sram(cyc));
      if (cyc >= 0) begin
        cyc++;
        if (cyc == 104) cyc = -1;
      end
    end
  end

  task automatic zero_mem();
    for (int unsigned i = 0; i < 256; i++) begin
      P[i] = '0; S1[i] = '0; S2[i] = '0; S3[i] = '0; S4[i] = '0;
    end
  endtask

  task automatic rand_mem();
    for (int unsigned i = 0; i < 256; i++) begin
      P[i] = $urandom; S1[i] = $urandom; S2[i] = $urandom;
      S3[i] = $urandom; S4[i] = $urandom;
    end
  endtask

  // Called at posedge+2; returns at posedge+2 of cycle 104 so a following
  // call exercises the earliest restart.
  task automatic run_op(input logic [31:0] l, input logic [31:0] r, input bit extra);
    bit got;
    int dcyc;
    got = 1'b0;
    dcyc = -1;
    bus.L = l;
    bus.R = r;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.L = $urandom;
    bus.R = $urandom;
    for (int n = 1; n < 200 && !got; n++) begin
      bus.start = (extra && (n == 5 || n == 50)) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (bus.done) begin got = 1'b1; dcyc = n; end
      @(posedge clk); #2;
    end
    bus.start = 1'b0;
    check("done_latency", 128'(dcyc), 128'd103);
  endtask

  logic [31:0] ml, mr;
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.L = '0;
    bus.R = '0;
    zero_mem();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    model(32'h01234567, 32'h89ABCDEF, ml, mr);
    check("model_zero", {ml, mr}, {32'h89ABCDEF, 32'h01234567});
    P[0] = 32'hFFFFFFFF;
    model(32'h01234567, 32'h89ABCDEF, ml, mr);
    check("model_p0", {ml, mr}, {32'h76543210, 32'h01234567});
    P[0] = '0;

    @(posedge clk); #2;
    run_op(32'h01234567, 32'h89ABCDEF, 1'b0);
    check("zero_key", {bus.resultL, bus.resultR}, {32'h89ABCDEF, 32'h01234567});
    P[0] = 32'hFFFFFFFF;
    run_op(32'h01234567, 32'h89ABCDEF, 1'b0);
    check("p0_ones", {bus.resultL, bus.resultR}, {32'h76543210, 32'h01234567});

    rand_mem();
    run_op($urandom, $urandom, 1'b1);

    // Abort mid-operation, then a clean operation must still work.
    zero_mem();
    bus.L = 32'hDEADBEEF;
    bus.R = 32'hCAFEF00D;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (39) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    run_op(32'h01234567, 32'h89ABCDEF, 1'b0);
    check("after_abort", {bus.resultL, bus.resultR}, {32'h89ABCDEF, 32'h01234567});

    for (int unsigned t = 0; t < 6; t++) begin
      rand_mem();
      run_op($urandom, $urandom, t[0]);
    end
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/feistel_decrypt.md
FEISTEL_DECRYPT -- requirements
Module: feistel_decrypt

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock domain.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to decrypt L/R; sampled only in IDLE.
REQ-004 L  input  32  ciphertext left half; captured on accepted start.
REQ-005 R  input  32  ciphertext right half; captured on accepted start.
REQ-006 s1_out, s2_out, s3_out, s4_out  input  32 each  S-box SRAM read data.
REQ-007 p_out  input  32  P-array SRAM read data.
REQ-008 s1_addr, s2_addr, s3_addr, s4_addr, p_addr  output  8 each  SRAM read addresses.
REQ-009 s1_cs_l, s2_cs_l, s3_cs_l, s4_cs_l, p_cs_l  output  1 each  active-low SRAM read strobes.
REQ-010 resultL, resultR  output  32 each  plaintext halves.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 SRAM timing SHALL be: strobe low with address in cycle t; data consumed from *_out in cycle t+2; strobes high and addresses 0 in every cycle without a request.
REQ-014 F(x) SHALL be ((S1[x[31:24]] + S2[x[23:16]]) ^ S3[x[15:8]]) + S4[x[7:0]], additions mod 2^32; S1..S4 addressed via s1..s4 ports.
REQ-015 States SHALL be IDLE, P_REQ, P_WAIT, P_XOR, S_REQ, S_WAIT, S_UPD, P1_REQ, P1_WAIT, P1_XOR, P0_REQ, P0_WAIT, P0_XOR, DONE; each non-IDLE state lasts exactly one cycle.
REQ-016 IDLE with start=1: load internal xL<=L, xR<=R, round counter<=0, go to P_REQ; start=0: stay in IDLE.
REQ-017 P_REQ: p_cs_l=0, p_addr=17-round; P_WAIT: no action; P_XOR: xL<=xL^p_out.
REQ-018 S_REQ: s1..s4_cs_l=0, addresses = xL bytes [31:24],[23:16],[15:8],[7:0]; S_WAIT: no action.
REQ-019 S_UPD with round<15: xL<=xR^F, xR<=xL, round<=round+1, next P_REQ.
REQ-020 S_UPD with round=15: xR<=xR^F, xL held (no swap), next P1_REQ.
REQ-021 P1_REQ reads p_addr=1, P1_XOR: xR<=xR^p_out; P0_REQ reads p_addr=0, P0_XOR: xL<=xL^p_out; each REQ followed by its WAIT then XOR state.
REQ-022 P0_XOR SHALL load resultL<=final xL, resultR<=xR; next DONE.
REQ-023 DONE: done=1 for exactly one cycle, next IDLE.
REQ-024 P addresses per operation SHALL be exactly 17,16,...,2,1,0 in order; 16 S-box reads total.
REQ-025 Latency: start accepted in cycle 0 gives done=1 in cycle 103 (96 round cycles plus 6 final cycles, then DONE); a new start is accepted in cycle 104 earliest.
REQ-026 start while busy SHALL be ignored; no queueing.
REQ-027 resultL/resultR SHALL hold the last plaintext until the next P0_XOR and SHALL NOT change during an operation.
REQ-028 At most one of {p, S-box group} SHALL be strobed in any cycle.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, round counter 0, xL/xR/resultL/resultR 0, busy 0, done 0, all cs_l 1, all addresses 0.
REQ-030 reset asserted mid-operation SHALL abort it without a done pulse; after release the block SHALL accept start normally.

Verification
REQ-031 Zero P and S memories; L=0x01234567, R=0x89ABCDEF -> resultL=0x89ABCDEF, resultR=0x01234567, done in cycle 103.
REQ-032 S zero, P[0]=0xFFFFFFFF, other P zero; same input -> resultL=0x76543210, resultR=0x01234567.
REQ-033 All-zero-key Blowfish schedule loaded; L=0x4EF99745, R=0x6198DD78 -> resultL=0x00000000, resultR=0x00000000.
REQ-034 Monitor the SRAM ports during any operation -> p_addr sequence 17..0, each read data used exactly 2 cycles after its strobe, never p and S strobed together.
REQ-035 start pulsed in cycles 5 and 50 of an operation -> ignored, single done in cycle 103, results unchanged until then.
REQ-036 reset asserted in cycle 40 and released, then start -> no done from the aborted operation, outputs 0 during reset, and the new operation matches REQ-031.
